// File: rtl/i2c_pkg.sv
// Shared constants for the I2C controller: FIFO sizing, TX word layout and
// bit positions inside the FIFO interrupt-request vector.
package i2c_pkg;

  localparam int I2C_FIFO_DEPTH = 16;
  localparam int OCY_W          = $clog2(I2C_FIFO_DEPTH) + 1;
  localparam int TX_W           = 10;
  localparam int RX_W           = 8;

  // TX command/data word layout: [7:0] data byte, then the two control flags
  localparam int TXW_START      = 8;
  localparam int TXW_STOP       = 9;

  // irq_fifo bit indices
  localparam int IRQ_W          = 5;
  localparam int IRQ_TX_EMPTY   = 0;
  localparam int IRQ_TX_HALF    = 1;
  localparam int IRQ_RX_PIRQ    = 2;
  localparam int IRQ_TX_OVF     = 3;
  localparam int IRQ_RX_UDF     = 4;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock first-word-fall-through FIFO on a flop array.
// Handshake: a push (wr) is accepted when the FIFO is not full, or when it is
// full and a pop (rd) happens in the same cycle; a pop is accepted only when
// the FIFO is not empty. Rejected strobes raise ovf/udf for that cycle only.
// srstn low flushes the FIFO and masks every strobe, including ovf/udf.
module i2c_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       srstn,
  input  logic                       wr,
  input  logic [W-1:0]               wdat,
  input  logic                       rd,
  output logic [W-1:0]               rdat,
  output logic [$clog2(DEPTH):0]     ocy,
  output logic [$clog2(DEPTH):0]     ocy_nxt,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] ocy_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (ocy_q == OW'(DEPTH));
  assign empty   = (ocy_q == '0);
  assign do_push = srstn & wr & (~full | rd);
  assign do_pop  = srstn & rd & ~empty;
  assign ovf     = srstn & wr & full & ~rd;
  assign udf     = srstn & rd & empty;
  assign ocy     = ocy_q;
  // Head word is read straight from the array: zero read latency
  assign rdat    = mem[rd_ptr];

  // Next occupancy; also exported so the top can detect transitions
  always_comb begin
    ocy_nxt = ocy_q;
    if (!srstn) begin
      ocy_nxt = '0;
    end else begin
      ocy_nxt = ocy_q + OW'(do_push) - OW'(do_pop);
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ocy_q  <= '0;
    end else if (!srstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ocy_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      ocy_q <= ocy_nxt;
    end
  end

  // Storage array; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdat;
  end

endmodule

// File: rtl/i2c_fifo_ctrl.sv
// TX/RX data FIFOs between the APB register block and the I2C byte engine,
// plus registered single-cycle FIFO interrupt-request pulses. Each pulse is
// derived from the current vs next occupancy so it appears in the same cycle
// the new occupancy becomes visible.
module i2c_fifo_ctrl
  import i2c_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               srstn,
  input  logic               tx_fifo_wr,
  input  logic [TX_W-1:0]    tx_fifo_wdat,
  output logic [OCY_W-1:0]   tx_fifo_ocy,
  input  logic               tx_rd,
  output logic [TX_W-1:0]    tx_rdat,
  output logic               tx_empty,
  input  logic               rx_wr,
  input  logic [RX_W-1:0]    rx_wdat,
  output logic               rx_full,
  input  logic               rx_fifo_rd,
  output logic [RX_W-1:0]    rx_fifo_rdat,
  output logic [OCY_W-1:0]   rx_fifo_ocy,
  input  logic [OCY_W-1:0]   rx_fifo_pirq,
  output logic [IRQ_W-1:0]   irq_fifo
);

  localparam int HALF = I2C_FIFO_DEPTH / 2;

  logic [OCY_W-1:0] tx_ocy_nxt;
  logic [OCY_W-1:0] rx_ocy_nxt;
  logic             tx_ovf;
  logic             rx_udf;
  logic             unused_tx_full;
  logic             unused_tx_udf;
  logic             unused_rx_empty;
  logic             unused_rx_ovf;
  logic [IRQ_W-1:0] irq_d;
  logic [OCY_W:0]   rx_old_x;
  logic [OCY_W:0]   rx_new_x;
  logic [OCY_W:0]   pirq_x;

  i2c_sync_fifo #(.DEPTH(I2C_FIFO_DEPTH), .W(TX_W)) u_tx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .srstn   (srstn),
    .wr      (tx_fifo_wr),
    .wdat    (tx_fifo_wdat),
    .rd      (tx_rd),
    .rdat    (tx_rdat),
    .ocy     (tx_fifo_ocy),
    .ocy_nxt (tx_ocy_nxt),
    .full    (unused_tx_full),
    .empty   (tx_empty),
    .ovf     (tx_ovf),
    .udf     (unused_tx_udf)
  );

  i2c_sync_fifo #(.DEPTH(I2C_FIFO_DEPTH), .W(RX_W)) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .srstn   (srstn),
    .wr      (rx_wr),
    .wdat    (rx_wdat),
    .rd      (rx_fifo_rd),
    .rdat    (rx_fifo_rdat),
    .ocy     (rx_fifo_ocy),
    .ocy_nxt (rx_ocy_nxt),
    .full    (rx_full),
    .empty   (unused_rx_empty),
    .ovf     (unused_rx_ovf),
    .udf     (rx_udf)
  );

  // One bit wider than the occupancy so pirq+1 can never wrap
  assign rx_old_x = {1'b0, rx_fifo_ocy};
  assign rx_new_x = {1'b0, rx_ocy_nxt};
  assign pirq_x   = {1'b0, rx_fifo_pirq};

  // Transition detection; a flush never raises a pulse
  always_comb begin
    irq_d = '0;
    if (srstn) begin
      irq_d[IRQ_TX_EMPTY] = (tx_fifo_ocy != '0) && (tx_ocy_nxt == '0);
      irq_d[IRQ_TX_HALF]  = (tx_fifo_ocy > OCY_W'(HALF)) && (tx_ocy_nxt <= OCY_W'(HALF));
      irq_d[IRQ_RX_PIRQ]  = (rx_old_x <= pirq_x) && (rx_new_x > pirq_x);
      irq_d[IRQ_TX_OVF]   = tx_ovf;
      irq_d[IRQ_RX_UDF]   = rx_udf;
    end
  end

  // Pulse register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_fifo <= '0;
    else       irq_fifo <= irq_d;
  end

endmodule

// File: tb/tb_i2c_fifo_ctrl.sv
// Self-checking bench for i2c_fifo_ctrl: directed scenarios followed by a
// randomized phase, all scored against a queue-based reference model.
module tb_i2c_fifo_ctrl;
  import i2c_pkg::*;

  localparam int DEPTH = I2C_FIFO_DEPTH;

  logic             clk = 1'b0;
  logic             rstn;
  logic             srstn;
  logic             tx_fifo_wr;
  logic [TX_W-1:0]  tx_fifo_wdat;
  logic [OCY_W-1:0] tx_fifo_ocy;
  logic             tx_rd;
  logic [TX_W-1:0]  tx_rdat;
  logic             tx_empty;
  logic             rx_wr;
  logic [RX_W-1:0]  rx_wdat;
  logic             rx_full;
  logic             rx_fifo_rd;
  logic [RX_W-1:0]  rx_fifo_rdat;
  logic [OCY_W-1:0] rx_fifo_ocy;
  logic [OCY_W-1:0] rx_fifo_pirq;
  logic [IRQ_W-1:0] irq_fifo;

  i2c_fifo_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .srstn        (srstn),
    .tx_fifo_wr   (tx_fifo_wr),
    .tx_fifo_wdat (tx_fifo_wdat),
    .tx_fifo_ocy  (tx_fifo_ocy),
    .tx_rd        (tx_rd),
    .tx_rdat      (tx_rdat),
    .tx_empty     (tx_empty),
    .rx_wr        (rx_wr),
    .rx_wdat      (rx_wdat),
    .rx_full      (rx_full),
    .rx_fifo_rd   (rx_fifo_rd),
    .rx_fifo_rdat (rx_fifo_rdat),
    .rx_fifo_ocy  (rx_fifo_ocy),
    .rx_fifo_pirq (rx_fifo_pirq),
    .irq_fifo     (irq_fifo)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  logic [TX_W-1:0]  exp_tx_q[$];
  logic [RX_W-1:0]  exp_rx_q[$];
  logic [IRQ_W-1:0] exp_irq;
  int total = 0;
  int bad   = 0;
  int cnt_irq[IRQ_W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: apply the strobes present before the coming edge
  task automatic model_step();
    int otx, orx, ntx, nrx, p;
    exp_irq = '0;
    if (!rstn || !srstn) begin
      exp_tx_q.delete();
      exp_rx_q.delete();
      return;
    end
    otx = exp_tx_q.size();
    orx = exp_rx_q.size();
    p   = int'(rx_fifo_pirq);
    if (tx_fifo_wr && otx == DEPTH && !tx_rd) exp_irq[IRQ_TX_OVF] = 1'b1;
    if (tx_rd && otx > 0) void'(exp_tx_q.pop_front());
    if (tx_fifo_wr && (otx < DEPTH || tx_rd)) exp_tx_q.push_back(tx_fifo_wdat);
    if (rx_fifo_rd && orx == 0) exp_irq[IRQ_RX_UDF] = 1'b1;
    if (rx_fifo_rd && orx > 0) void'(exp_rx_q.pop_front());
    if (rx_wr && (orx < DEPTH || rx_fifo_rd)) exp_rx_q.push_back(rx_wdat);
    ntx = exp_tx_q.size();
    nrx = exp_rx_q.size();
    exp_irq[IRQ_TX_EMPTY] = (otx != 0) && (ntx == 0);
    exp_irq[IRQ_TX_HALF]  = (otx > DEPTH / 2) && (ntx <= DEPTH / 2);
    exp_irq[IRQ_RX_PIRQ]  = (orx <= p) && (nrx > p);
  endtask

  task automatic check_outputs();
    check("tx_ocy",   32'(tx_fifo_ocy), 32'(exp_tx_q.size()));
    check("tx_empty", 32'(tx_empty),    32'(exp_tx_q.size() == 0));
    check("rx_ocy",   32'(rx_fifo_ocy), 32'(exp_rx_q.size()));
    check("rx_full",  32'(rx_full),     32'(exp_rx_q.size() == DEPTH));
    check("irq",      32'(irq_fifo),    32'(exp_irq));
    if (exp_tx_q.size() > 0) check("tx_rdat", 32'(tx_rdat), 32'(exp_tx_q[0]));
    if (exp_rx_q.size() > 0) check("rx_rdat", 32'(rx_fifo_rdat), 32'(exp_rx_q[0]));
    for (int i = 0; i < IRQ_W; i++) if (irq_fifo[i]) cnt_irq[i]++;
  endtask

  // One clock: model update, edge, then check away from the edge
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    tx_fifo_wr = 1'b0;
    tx_rd      = 1'b0;
    rx_wr      = 1'b0;
    rx_fifo_rd = 1'b0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < IRQ_W; i++) cnt_irq[i] = 0;
  endtask

  task automatic tx_push(input logic [TX_W-1:0] d);
    idle(); tx_fifo_wr = 1'b1; tx_fifo_wdat = d; tick(); idle();
  endtask

  task automatic tx_pop();
    idle(); tx_rd = 1'b1; tick(); idle();
  endtask

  task automatic rx_push(input logic [RX_W-1:0] d);
    idle(); rx_wr = 1'b1; rx_wdat = d; tick(); idle();
  endtask

  task automatic rx_pop();
    idle(); rx_fifo_rd = 1'b1; tick(); idle();
  endtask

  task automatic drain_all();
    idle();
    tx_rd = 1'b1;
    rx_fifo_rd = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    idle();
    tick();
  endtask

  logic [RX_W-1:0] last_rx;

  initial begin
    // Reset with pushes active
    rstn = 1'b1; srstn = 1'b1; rx_fifo_pirq = 5'd3;
    tx_fifo_wr = 1'b1; tx_fifo_wdat = 10'h155; tx_rd = 1'b0;
    rx_wr = 1'b1; rx_wdat = 8'h33; rx_fifo_rd = 1'b0;
    clear_counts();
    #1 rstn = 1'b0;
    #1;
    check("rst_tx_ocy",   32'(tx_fifo_ocy), 32'd0);
    check("rst_tx_empty", 32'(tx_empty),    32'd1);
    check("rst_rx_ocy",   32'(rx_fifo_ocy), 32'd0);
    check("rst_irq",      32'(irq_fifo),    32'd0);
    exp_irq = '0;
    for (int i = 0; i < 3; i++) tick();
    idle();
    @(negedge clk) rstn = 1'b1;
    tick();

    // Async reset in the middle of traffic
    for (int i = 0; i < 5; i++) begin
      tx_push(TX_W'(i + 1));
      rx_push(RX_W'(i + 8'h40));
    end
    #3 rstn = 1'b0;
    #1;
    check("arst_tx_ocy", 32'(tx_fifo_ocy), 32'd0);
    check("arst_rx_ocy", 32'(rx_fifo_ocy), 32'd0);
    check("arst_irq",    32'(irq_fifo),    32'd0);
    exp_tx_q.delete(); exp_rx_q.delete(); exp_irq = '0;
    tx_fifo_wr = 1'b1;
    tick(); tick();
    idle();
    @(negedge clk) rstn = 1'b1;
    tick();

    // Order, overflow and pointer wrap, three rounds
    for (int rep = 0; rep < 3; rep++) begin
      clear_counts();
      tx_push(10'h301);
      for (int v = 2; v <= 16; v++) tx_push(TX_W'(v));
      check("fill_ocy", 32'(tx_fifo_ocy), 32'd16);
      tx_push(10'h0AA);
      check("ovf_pulses", 32'(cnt_irq[IRQ_TX_OVF]), 32'd1);
      check("ovf_ocy", 32'(tx_fifo_ocy), 32'd16);
      for (int i = 0; i < DEPTH; i++) tx_pop();
      check("half_pulses",  32'(cnt_irq[IRQ_TX_HALF]),  32'd1);
      check("empty_pulses", 32'(cnt_irq[IRQ_TX_EMPTY]), 32'd1);
    end

    // Simultaneous push/pop on full and empty RX
    rx_fifo_pirq = 5'd20;
    for (int i = 0; i < DEPTH; i++) rx_push(RX_W'($urandom_range(0, 255)));
    idle(); rx_wr = 1'b1; rx_wdat = 8'h5A; rx_fifo_rd = 1'b1; tick(); idle();
    check("full_pp_ocy", 32'(rx_fifo_ocy), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      last_rx = rx_fifo_rdat;
      rx_pop();
    end
    check("last_out", 32'(last_rx), 32'h5A);
    clear_counts();
    idle(); rx_wr = 1'b1; rx_wdat = 8'hC3; rx_fifo_rd = 1'b1; tick(); idle();
    check("empty_pp_ocy", 32'(rx_fifo_ocy), 32'd1);
    check("empty_pp_udf", 32'(cnt_irq[IRQ_RX_UDF]), 32'd1);
    rx_pop();

    // RX threshold pulses
    rx_fifo_pirq = 5'd3;
    tick();
    clear_counts();
    for (int i = 0; i < 4; i++) rx_push(RX_W'(8'h10 + i));
    check("pirq_first", 32'(cnt_irq[IRQ_RX_PIRQ]), 32'd1);
    rx_pop();
    rx_push(8'h20);
    check("pirq_second", 32'(cnt_irq[IRQ_RX_PIRQ]), 32'd2);
    rx_fifo_pirq = 5'd15;
    tick(); tick();
    check("pirq_thr_change", 32'(cnt_irq[IRQ_RX_PIRQ]), 32'd2);
    drain_all();

    // Soft reset flush
    for (int i = 0; i < 7; i++) tx_push(TX_W'(10'h200 + i));
    clear_counts();
    srstn = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tx_fifo_wr = i[0];
      tx_fifo_wdat = TX_W'($urandom_range(0, 1023));
      tick();
    end
    idle();
    srstn = 1'b1;
    check("srst_ocy", 32'(tx_fifo_ocy), 32'd0);
    check("srst_irqs", 32'(cnt_irq[0] + cnt_irq[1] + cnt_irq[2] + cnt_irq[3] + cnt_irq[4]), 32'd0);
    tx_push(10'h123);
    check("srst_head", 32'(tx_rdat), 32'h123);
    tx_pop();

    // RX underflow leaves pointers intact
    clear_counts();
    rx_pop();
    check("udf_pulse", 32'(cnt_irq[IRQ_RX_UDF]), 32'd1);
    check("udf_ocy", 32'(rx_fifo_ocy), 32'd0);
    rx_push(8'h77);
    check("udf_head", 32'(rx_fifo_rdat), 32'h77);
    rx_pop();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tx_fifo_wr   = ($urandom_range(0, 99) < 55);
      tx_fifo_wdat = TX_W'($urandom_range(0, 1023));
      tx_rd        = ($urandom_range(0, 99) < 45);
      rx_wr        = ($urandom_range(0, 99) < 50);
      rx_wdat      = RX_W'($urandom_range(0, 255));
      rx_fifo_rd   = ($urandom_range(0, 99) < 50);
      srstn        = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) rx_fifo_pirq = OCY_W'($urandom_range(0, 31));
      tick();
    end
    idle();
    srstn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
